// File: rtl/aes128_inv_core.sv
// Iterative AES-128 decryptor with one-entry key cache; done 21 cycles after start on a key miss, 11 on a hit.
// No backpressure: start is ignored while busy, and plaintext holds until the next done pulse.
module aes128_inv_core #(
    parameter int FAULT_ROUND = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    input  logic         cache_invalidate,
    input  logic         fault_inject,
    output logic [127:0] plaintext,
    output logic         done,
    output logic         busy,
    output logic         key_hit
);
    typedef enum logic [1:0] {IDLE, KEXP, ROUND} fsm_t;

    fsm_t         fsm;
    logic [127:0] st, rk, ct_reg, key_reg, cached_key, last_rk;
    logic [3:0]   kctr, rnd;
    logic         cache_valid;
    logic [127:0] fwd_rk, prk, round_out;
    logic         hit;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), avoiding S-box tables.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq, res;
        sq  = a;
        res = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            res = gmul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = ginv(x);
        return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] n);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(n), 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recovers round key n-1 from round key n.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [3:0] n);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rcon(n), 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t, m;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
        t = t ^ k;
        m = t;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127 - 32*c -: 8];
            a1 = t[119 - 32*c -: 8];
            a2 = t[111 - 32*c -: 8];
            a3 = t[103 - 32*c -: 8];
            m[127 - 32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return last ? t : m;
    endfunction

    always_comb begin
        fwd_rk    = key_fwd(rk, kctr);
        prk       = key_inv(rk, rnd);
        round_out = inv_round(st, prk, rnd == 4'd1) ^
                    {127'b0, fault_inject && (rnd == 4'(FAULT_ROUND))};
        hit       = cache_valid && (key == cached_key) && !cache_invalidate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            st          <= '0;
            rk          <= '0;
            ct_reg      <= '0;
            key_reg     <= '0;
            cached_key  <= '0;
            last_rk     <= '0;
            kctr        <= '0;
            rnd         <= '0;
            cache_valid <= 1'b0;
            plaintext   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            key_hit     <= 1'b0;
        end else begin
            done    <= 1'b0;
            key_hit <= 1'b0;
            if (cache_invalidate) cache_valid <= 1'b0;
            case (fsm)
                IDLE: if (start) begin
                    ct_reg  <= ciphertext;
                    key_reg <= key;
                    busy    <= 1'b1;
                    if (hit) begin
                        st      <= ciphertext ^ last_rk;
                        rk      <= last_rk;
                        rnd     <= 4'd10;
                        key_hit <= 1'b1;
                        fsm     <= ROUND;
                    end else begin
                        rk   <= key;
                        kctr <= 4'd1;
                        fsm  <= KEXP;
                    end
                end
                KEXP: begin
                    rk <= fwd_rk;
                    if (kctr == 4'd10) begin
                        last_rk     <= fwd_rk;
                        cached_key  <= key_reg;
                        cache_valid <= !cache_invalidate;
                        st          <= ct_reg ^ fwd_rk;
                        rnd         <= 4'd10;
                        fsm         <= ROUND;
                    end else begin
                        kctr <= kctr + 4'd1;
                    end
                end
                ROUND: begin
                    st <= round_out;
                    rk <= prk;
                    if (rnd == 4'd1) begin
                        plaintext <= round_out;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/aes128_inv_core.md
Name: aes128_inv_core

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart of the team's iterative AES-128 encryption core, and uses the same one-round-per-clock structure and start/busy/done handshake.
- On a key change, the block first runs the forward key schedule to derive round key 10. It then decrypts while unrolling the key schedule backwards, one round key per round.
- A one-entry key cache skips the expansion phase when the key repeats.

Parameters:
- FAULT_ROUND, 5, decryption round index at which fault_inject flips bit 0 of the round result.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- ciphertext  input  128  block to decrypt, byte 0 = bits [127:120]; sampled on the accepted start edge.
- key  input  128  cipher key, same byte order; sampled on the accepted start edge.
- cache_invalidate  input  1  clears the key cache.
- fault_inject  input  1  test hook, bit-flip injection.
- plaintext  output  128  result; holds until the next completion.
- done  output  1  one-cycle pulse when plaintext updates.
- busy  output  1  high from the accepted start until done.
- key_hit  output  1  one-cycle pulse on an accepted start that hit the cache.

Behaviour:
- Reset (async, rst_n=0):
  - plaintext=0, done=0, busy=0, key_hit=0.
  - Internal state, round key, counters, cached_key and last_rk cleared; cache_valid=0; FSM=IDLE.
  - Reset mid-operation aborts the operation immediately; no done is produced.
- FSM states: IDLE, KEXP, ROUND.
- IDLE, start=1 (busy=0): latch ciphertext into ct_reg and key into key_reg; busy<=1.
  - Hit (cache_valid && key==cached_key && !cache_invalidate): state<=ciphertext^last_rk, rk<=last_rk, rnd<=10, key_hit<=1, go to ROUND.
  - Otherwise: rk<=key, kctr<=1, go to KEXP.
- KEXP, one step per cycle: rk<=fwd(rk,kctr), with the standard expansion (RotWord, SubWord, rcon(kctr) in the MS byte of word 0).
  - At kctr==10: last_rk<=fwd result, cached_key<=key_reg, cache_valid<=1, state<=ct_reg^fwd result, rk<=fwd result, rnd<=10, go to ROUND.
  - Otherwise kctr<=kctr+1.
- ROUND r, r counts 10 down to 1, one round per cycle:
  - prk = inverse key step of rk for round r. With rk={w0,w1,w2,w3}: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^{rcon(r),24'h0}.
  - t = InvSubBytes(InvShiftRows(state)) ^ prk.
  - new = (r==1) ? t : InvMixColumns(t).
  - If fault_inject && r==FAULT_ROUND: new[0] inverted.
  - state<=new, rk<=prk.
  - At r==1: plaintext<=new, done<=1, busy<=0, go to IDLE. Otherwise r<=r-1.
- InvShiftRows: out[r+4c]=in[r+4((c-r) mod 4)]. InvMixColumns uses coefficients 0e,0b,0d,09 over GF(2^8) modulo 0x11b.
- Latency, counting the accepted start edge as edge 1:
  - Cache miss: done high after edge 21.
  - Cache hit: done high after edge 11.
  - Back-to-back: start may be asserted on the cycle done is high; it is accepted on the next edge because busy is 0.
- Simultaneous events:
  - start while busy=1 is ignored; inputs are not resampled.
  - ciphertext/key changes mid-operation have no effect.
  - cache_invalidate has priority over a concurrent hit. It does not abort a running KEXP; the cache is rewritten when KEXP completes, unless cache_invalidate is high on that same edge, in which case cache_valid stays 0.
- done and key_hit are deasserted by default every cycle.

Test Plan:
- FIPS-197 App.B, cold cache: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734, done after edge 21, key_hit=0, internal last_rk=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, then the App.C.1 ct 69c4e0d86a7b0430d8cdb78070b4c55a with key 000102030405060708090a0b0c0d0e0f:
  - First run hits the cache: key_hit pulse, done at edge 11, correct App.B result.
  - Second run misses: done at edge 21, plaintext 00112233445566778899aabbccddeeff.
- cache_invalidate for one cycle, then a start with the same key -> miss, 21-cycle latency, correct result; invalidate concurrent with start -> also a miss.
- start pulsed while busy, plus ciphertext/key toggled mid-operation -> a single done, original result, busy held continuously.
- fault_inject=1 on the App.C.1 vector -> plaintext != 00112233445566778899aabbccddeeff; rerun with fault_inject=0 -> correct.
- rst_n low at ROUND r=6 -> all outputs 0 immediately, no done; the next start with the previously cached key misses (21 cycles).
